// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback port arbiter.
// Optional feature macro used by the arbiter: WB_ARB_RR_EN (round-robin tie break).
package wb_port_arbiter_pkg;

    // Default architectural sizing of the register file.
    localparam int REG_NUM_DEF    = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    // Outcome of one arbitration cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } grant_e;

    // Identity of a writeback producer.
    typedef enum logic {
        PORT_LOAD = 1'b0,
        PORT_ALU  = 1'b1
    } port_e;

    // Pick at most one requester; prefer1 decides only a tie.
    function automatic grant_e arbitrate(input logic v0, input logic v1, input logic prefer1);
        if (v0 && v1) begin
            return prefer1 ? GNT_P1 : GNT_P0;
        end else if (v0) begin
            return GNT_P0;
        end else if (v1) begin
            return GNT_P1;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// Per-register pending-write scoreboard used by decode for RAW stalls.
// A bit is set when decode issues a writer of that register and cleared on the
// edge where the matching writeback is registered; a set on the same edge wins.
// Register 0 is hardwired zero and never reports busy.
module wb_port_arbiter_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int REG_NUM    = REG_NUM_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] qry_addr1,
    input  logic [REG_ADDR_W-1:0] qry_addr2,
    output logic                  qry_busy1,
    output logic                  qry_busy2
);

    // Every register except x0 can be tracked.
    localparam logic [REG_NUM-1:0] TRACK_MASK = {{(REG_NUM-1){1'b1}}, 1'b0};

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_d;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;

    // Decode set/clear requests into one-hot vectors and form the next state.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        set_vec = '0;
        clr_vec = '0;
        if (set_valid) set_vec[set_addr] = 1'b1;
        if (clr_valid) clr_vec[clr_addr] = 1'b1;
        if (flush) begin
            pending_d = '0;
        end else begin
            // Set is applied after clear so a newer outstanding producer survives.
            pending_d = ((pending & ~clr_vec) | set_vec) & TRACK_MASK;
        end
    end

    // Pending flags are state the stall logic trusts, so they are reset like any control register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the vector is only 32 flops of control state, not a RAM, so an async reset is cheap and required here.
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    // Query ports are combinational so decode sees the current-cycle state.
    assign qry_busy1 = pending[qry_addr1];
    assign qry_busy2 = pending[qry_addr2];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for two writeback producers:
//   port 0 = load/memory path, port 1 = ALU/execute path.
// At most one request is accepted per cycle and its write is presented to the
// regfile one cycle later from registers, so the regfile write-through bypass
// covers a hazard that clears on the same edge.
// Configuration macro WB_ARB_RR_EN: when defined, ties alternate round-robin
// using a one-bit last_grant register; when undefined, port 0 always wins ties.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int REG_NUM    = REG_NUM_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    input  logic                  alloc_valid,
    input  logic [REG_ADDR_W-1:0] alloc_addr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] qry_addr1,
    input  logic [REG_ADDR_W-1:0] qry_addr2,
    output logic                  qry_busy1,
    output logic                  qry_busy2,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]     wb_wdata
);

    grant_e                grant;
    logic                  prefer1;
    logic                  fire;
    logic                  real_write;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;

`ifdef WB_ARB_RR_EN
    port_e last_grant;

    // On a tie, favour the port that did not win the previous grant.
    assign prefer1 = (last_grant == PORT_LOAD);

    // Remember the winner of every grant; after reset port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= PORT_ALU;
        end else if (grant == GNT_P0) begin
            last_grant <= PORT_LOAD;
        end else if (grant == GNT_P1) begin
            last_grant <= PORT_ALU;
        end
    end
`else
    // A load has nowhere else to hold its data, so it always wins a tie.
    assign prefer1 = 1'b0;
`endif

    // Choose this cycle's winner; nothing is granted in reset or during a flush.
    always_comb begin
        grant = GNT_NONE;
        if (rst && !flush) begin
            grant = arbitrate(req0_valid, req1_valid, prefer1);
        end
    end

    assign req0_ready = (grant == GNT_P0);
    assign req1_ready = (grant == GNT_P1);

    // Steer the winning request's destination and data toward the output register.
    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (grant == GNT_P1) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    assign fire       = (grant != GNT_NONE);
    // Writes to x0 are accepted and dropped.
    assign real_write = fire && (sel_addr != '0);

    // Present the accepted write to the regfile for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else begin
            wb_we <= real_write;
            if (fire) begin
                wb_waddr <= sel_addr;
                wb_wdata <= sel_data;
            end
        end
    end

    wb_port_arbiter_scoreboard #(
        .REG_NUM    (REG_NUM),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (alloc_valid),
        .set_addr  (alloc_addr),
        .clr_valid (real_write),
        .clr_addr  (sel_addr),
        .flush     (flush),
        .qry_addr1 (qry_addr1),
        .qry_addr2 (qry_addr2),
        .qry_busy1 (qry_busy1),
        .qry_busy2 (qry_busy2)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled away from the edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, alloc_valid, flush;
    logic [4:0]  req0_addr, req1_addr, alloc_addr, qry_addr1, qry_addr2;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, qry_busy1, qry_busy2, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .qry_addr1   (qry_addr1),
        .qry_addr2   (qry_addr2),
        .qry_busy1   (qry_busy1),
        .qry_busy2   (qry_busy2),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        qry_addr1 = 5'd1; qry_addr2 = 5'd2;
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        alloc_valid = 1'b1; alloc_addr = 5'd1;
        @(posedge clk); @(posedge clk); #1;
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", wb_we); end
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%0b exp=0", req1_ready); end
        total++; if (qry_busy1 !== 1'b0 || qry_busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b%0b exp=00", qry_busy1, qry_busy2); end
        total++; if (wb_waddr !== 5'd0 || wb_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", wb_waddr, wb_wdata); end
        idle_inputs();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hDEADBEEF;
        #1;
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%0b%0b exp=10", req1_ready, req0_ready); end
        step();
        req1_valid = 1'b0;
        total++; if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_write got=%0b/%0d/%h exp=1/5/deadbeef", wb_we, wb_waddr, wb_wdata); end
        step();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%0b exp=0", wb_we); end
    endtask

    task automatic test_contention();
        logic [4:0] exp_second_addr;
        logic       exp_second_r1;
`ifdef WB_ARB_RR_EN
        exp_second_addr = 5'd4; exp_second_r1 = 1'b1;
`else
        exp_second_addr = 5'd3; exp_second_r1 = 1'b0;
`endif
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA0003;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hBBBB0004;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL cont_first got=%0b%0b exp=10", req0_ready, req1_ready); end
        step();
        total++; if (wb_we !== 1'b1 || wb_waddr !== 5'd3 || wb_wdata !== 32'hAAAA0003) begin bad++; $display("FAIL cont_first_wb got=%0b/%0d/%h exp=1/3/aaaa0003", wb_we, wb_waddr, wb_wdata); end
        #1;
        total++; if (req1_ready !== exp_second_r1 || req0_ready !== !exp_second_r1) begin bad++; $display("FAIL cont_second got=%0b%0b exp=%0b%0b", req0_ready, req1_ready, !exp_second_r1, exp_second_r1); end
        step();
        idle_inputs();
        total++; if (wb_we !== 1'b1 || wb_waddr !== exp_second_addr) begin bad++; $display("FAIL cont_second_wb got=%0b/%0d exp=1/%0d", wb_we, wb_waddr, exp_second_addr); end
        step();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL cont_idle got=%0b exp=0", wb_we); end
    endtask

    task automatic test_scoreboard();
        qry_addr1 = 5'd7; qry_addr2 = 5'd8;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        #1;
        total++; if (qry_busy1 !== 1'b0) begin bad++; $display("FAIL sb_before got=%0b exp=0", qry_busy1); end
        step();
        alloc_valid = 1'b0;
        #1;
        total++; if (qry_busy1 !== 1'b1 || qry_busy2 !== 1'b0) begin bad++; $display("FAIL sb_set got=%0b%0b exp=10", qry_busy1, qry_busy2); end
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h00000077;
        #1;
        total++; if (req0_ready !== 1'b1 || qry_busy1 !== 1'b1) begin bad++; $display("FAIL sb_grant_cycle got=%0b%0b exp=11", req0_ready, qry_busy1); end
        step();
        req0_valid = 1'b0;
        total++; if (qry_busy1 !== 1'b0 || wb_we !== 1'b1 || wb_waddr !== 5'd7) begin bad++; $display("FAIL sb_clear got=%0b/%0b/%0d exp=0/1/7", qry_busy1, wb_we, wb_waddr); end
        req0_valid = 1'b1; req0_data = 32'h00000078;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        step();
        idle_inputs();
        total++; if (qry_busy1 !== 1'b1 || wb_we !== 1'b1 || wb_wdata !== 32'h00000078) begin bad++; $display("FAIL sb_set_wins got=%0b/%0b/%h exp=1/1/00000078", qry_busy1, wb_we, wb_wdata); end
        step();
    endtask

    task automatic test_x0();
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h00001234;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b exp=1", req0_ready); end
        step();
        req0_valid = 1'b0;
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%0b exp=0", wb_we); end
        alloc_valid = 1'b1; alloc_addr = 5'd0; qry_addr2 = 5'd0;
        step();
        alloc_valid = 1'b0;
        #1;
        total++; if (qry_busy2 !== 1'b0) begin bad++; $display("FAIL x0_busy got=%0b exp=0", qry_busy2); end
    endtask

    task automatic test_flush();
        alloc_valid = 1'b1; alloc_addr = 5'd2;
        step();
        alloc_addr = 5'd9;
        step();
        alloc_valid = 1'b0;
        qry_addr1 = 5'd2; qry_addr2 = 5'd9;
        #1;
        total++; if (qry_busy1 !== 1'b1 || qry_busy2 !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0b%0b exp=11", qry_busy1, qry_busy2); end
        flush = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h0000F00D;
        alloc_valid = 1'b1; alloc_addr = 5'd11;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b%0b exp=00", req0_ready, req1_ready); end
        step();
        flush = 1'b0; alloc_valid = 1'b0;
        #1;
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL flush_no_write got=%0b exp=0", wb_we); end
        total++; if (qry_busy1 !== 1'b0 || qry_busy2 !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0b%0b exp=00", qry_busy1, qry_busy2); end
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL flush_regrant got=%0b exp=1", req0_ready); end
        qry_addr1 = 5'd7; qry_addr2 = 5'd11;
        #1;
        total++; if (qry_busy1 !== 1'b0 || qry_busy2 !== 1'b0) begin bad++; $display("FAIL flush_wins got=%0b%0b exp=00", qry_busy1, qry_busy2); end
        step();
        req0_valid = 1'b0;
        total++; if (wb_we !== 1'b1 || wb_waddr !== 5'd2 || wb_wdata !== 32'h0000F00D) begin bad++; $display("FAIL flush_write got=%0b/%0d/%h exp=1/2/0000f00d", wb_we, wb_waddr, wb_wdata); end
        step();
    endtask

    task automatic test_back_to_back();
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h10101010;
        step();
        req1_addr = 5'd11; req1_data = 32'h11111111;
        total++; if (wb_we !== 1'b1 || wb_waddr !== 5'd10 || wb_wdata !== 32'h10101010) begin bad++; $display("FAIL b2b_first got=%0b/%0d/%h exp=1/10/10101010", wb_we, wb_waddr, wb_wdata); end
        step();
        req1_valid = 1'b0;
        total++; if (wb_we !== 1'b1 || wb_waddr !== 5'd11 || wb_wdata !== 32'h11111111) begin bad++; $display("FAIL b2b_second got=%0b/%0d/%h exp=1/11/11111111", wb_we, wb_waddr, wb_wdata); end
        step();
    endtask

    task automatic test_reset_mid();
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h00000066;
        alloc_valid = 1'b1; alloc_addr = 5'd12; qry_addr1 = 5'd12;
        step();
        alloc_valid = 1'b0;
        total++; if (wb_we !== 1'b1 || qry_busy1 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0b%0b exp=11", wb_we, qry_busy1); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (wb_we !== 1'b0 || wb_waddr !== 5'd0 || wb_wdata !== 32'd0) begin bad++; $display("FAIL mid_async got=%0b/%0d/%h exp=0/0/0", wb_we, wb_waddr, wb_wdata); end
        total++; if (qry_busy1 !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_state got=%0b%0b exp=00", qry_busy1, req1_ready); end
        idle_inputs();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_x0();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
